instruction_memory_loadable: RTL and testbench

Parametrised successor to the fixed instruction ROM. It holds a DEPTH-entry program store that powers up with the built-in default program. The store can be rewritten at run time through a sequential load port with a valid/ready handshake. Instruction fetch is a registered read with a valid flag. It sits between the program counter and the instruction decoder, with the load port driven by the board's program loader.

---
 rtl/instruction_memory_loadable.sv | 126 ++++++++++++
 tb/tb_instruction_memory_loadable.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_memory_loadable.sv
// Loadable instruction store: registered fetch port plus a sequential valid/ready load port.
// Powers up and resets to the built-in default program.
module instruction_memory_loadable #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 32
) (
    input  logic                  input_Clock,
    input  logic                  input_Reset,
    input  logic                  input_Fetch_Valid,
    input  logic [ADDR_WIDTH-1:0] input_Address,
    output logic [DATA_WIDTH-1:0] output_Instruction,
    output logic                  output_Instruction_Valid,
    input  logic                  input_Load_Start,
    input  logic                  input_Load_Valid,
    input  logic [DATA_WIDTH-1:0] input_Load_Data,
    output logic                  output_Load_Ready,
    output logic                  output_Load_Done,
    output logic                  output_Busy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Load handshake: a word transfers on a rising edge where
    // input_Load_Valid && output_Load_Ready; Ready is a pure state decode.
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_LOAD = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [PTR_W-1:0]        ptr_q, ptr_d;
    logic                    done_q, done_d;
    logic [DATA_WIDTH-1:0]   instr_q, instr_d;
    logic                    instr_valid_q, instr_valid_d;
    logic                    mem_we;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    // Default bytes are zero-extended or truncated to DATA_WIDTH.
    function automatic logic [DATA_WIDTH-1:0] default_word(input int idx);
        logic [7:0]            b;
        logic [DATA_WIDTH-1:0] w;
        case (idx)
            0:       b = 8'h49;
            1:       b = 8'hC1;
            2:       b = 8'h18;
            3:       b = 8'hA9;
            4:       b = 8'h4D;
            default: b = 8'h00;
        endcase
        w = '0;
        for (int k = 0; k < DATA_WIDTH && k < 8; k++) begin
            w[k] = b[k];
        end
        return w;
    endfunction

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        done_d        = 1'b0;
        mem_we        = 1'b0;
        instr_d       = instr_q;
        instr_valid_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (input_Load_Start) begin
                    state_d = ST_LOAD;
                    ptr_d   = '0;
                end else if (input_Fetch_Valid) begin
                    instr_d       = mem_q[input_Address[PTR_W-1:0]];
                    instr_valid_d = 1'b1;
                end
            end
            ST_LOAD: begin
                // Start outranks a same-cycle transfer: the word is discarded.
                if (input_Load_Start) begin
                    ptr_d = '0;
                end else if (input_Load_Valid) begin
                    mem_we = 1'b1;
                    if (ptr_q == PTR_W'(DEPTH - 1)) begin
                        state_d = ST_RUN;
                        ptr_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        ptr_d = ptr_q + PTR_W'(1);
                    end
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge input_Clock or posedge input_Reset) begin
        if (input_Reset) begin
            state_q       <= ST_RUN;
            ptr_q         <= '0;
            done_q        <= 1'b0;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            done_q        <= done_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    always_ff @(posedge input_Clock or posedge input_Reset) begin
        if (input_Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= default_word(i);
            end
        end else if (mem_we) begin
            mem_q[ptr_q] <= input_Load_Data;
        end
    end

    assign output_Instruction       = instr_q;
    assign output_Instruction_Valid = instr_valid_q;
    assign output_Load_Ready        = (state_q == ST_LOAD);
    assign output_Busy              = (state_q == ST_LOAD);
    assign output_Load_Done         = done_q;

endmodule

// File: tb/tb_instruction_memory_loadable.sv
// Randomised, self-checking bench for instruction_memory_loadable against a
// whole-program reference array.
module tb_instruction_memory_loadable;
  localparam int DW = 8;
  localparam int AW = 8;
  localparam int D  = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fetch_valid = 1'b0;
  logic [AW-1:0] address = '0;
  logic [DW-1:0] instr;
  logic          instr_valid;
  logic          load_start = 1'b0;
  logic          load_valid = 1'b0;
  logic [DW-1:0] load_data = '0;
  logic          load_ready;
  logic          load_done;
  logic          busy;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] model_mem [D];
  logic [DW-1:0] exp_instr;
  logic [DW-1:0] exp_q [$];

  instruction_memory_loadable #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(D)) dut (
    .input_Clock             (clk),
    .input_Reset             (rst),
    .input_Fetch_Valid       (fetch_valid),
    .input_Address           (address),
    .output_Instruction      (instr),
    .output_Instruction_Valid(instr_valid),
    .input_Load_Start        (load_start),
    .input_Load_Valid        (load_valid),
    .input_Load_Data         (load_data),
    .output_Load_Ready       (load_ready),
    .output_Load_Done        (load_done),
    .output_Busy             (busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_default();
    for (int i = 0; i < D; i++) model_mem[i] = '0;
    model_mem[0] = 8'h49;
    model_mem[1] = 8'hC1;
    model_mem[2] = 8'h18;
    model_mem[3] = 8'hA9;
    model_mem[4] = 8'h4D;
  endtask

  task automatic drive_idle();
    fetch_valid = 1'b0;
    load_start  = 1'b0;
    load_valid  = 1'b0;
    load_data   = '0;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    model_default();
    exp_instr = '0;
    tick();
    tick();
    total++;
    if ({instr, instr_valid, load_ready, load_done, busy} !== {8'h00, 4'b0000}) begin
      bad++;
      $display("FAIL reset_outputs got instr=%h v=%b rdy=%b done=%b busy=%b want all 0",
               instr, instr_valid, load_ready, load_done, busy);
    end
    rst = 1'b0;
    tick();
    total++;
    if (instr_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL after_reset_idle got v=%b busy=%b want 0 0", instr_valid, busy);
    end
  endtask

  task automatic test_fetch_default();
    for (int i = 0; i < 6; i++) begin
      fetch_valid = 1'b1;
      address     = AW'(i);
      tick();
      exp_instr = model_mem[i];
      total++;
      if (instr !== exp_instr || instr_valid !== 1'b1) begin
        bad++;
        $display("FAIL fetch_default[%0d] got %h v=%b want %h v=1", i, instr, instr_valid, exp_instr);
      end
    end
    fetch_valid = 1'b0;
  endtask

  task automatic test_wrap_and_hold();
    fetch_valid = 1'b0;
    address     = 8'h23;
    tick();
    total++;
    if (instr !== exp_instr || instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL hold_idle got %h v=%b want %h v=0", instr, instr_valid, exp_instr);
    end
    fetch_valid = 1'b1;
    tick();
    exp_instr = model_mem[8'h23 % D];
    total++;
    if (instr !== 8'hA9 || instr !== exp_instr || instr_valid !== 1'b1) begin
      bad++;
      $display("FAIL addr_wrap got %h v=%b want a9 v=1", instr, instr_valid);
    end
    fetch_valid = 1'b0;
    tick();
    total++;
    if (instr !== exp_instr || instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL hold_after_wrap got %h v=%b want %h v=0", instr, instr_valid, exp_instr);
    end
  endtask

  // Feeds D words; valid pattern chosen by mode (0 all, 1 toggle, 2 random).
  task automatic load_words(input int mode, input logic [DW-1:0] base, input bit rnd_data,
                            output int done_cnt);
    int idx;
    int cyc;
    bit lv;
    idx = 0;
    cyc = 0;
    done_cnt = 0;
    while (idx < D && cyc < 400) begin
      case (mode)
        0: lv = 1'b1;
        1: lv = cyc[0];
        default: lv = ($urandom_range(0, 2) != 0);
      endcase
      load_valid = lv;
      load_data  = rnd_data ? DW'($urandom) : base + DW'(idx);
      tick();
      cyc++;
      if (lv) begin
        model_mem[idx] = load_data;
        idx++;
      end
      if (load_done === 1'b1) done_cnt++;
      total++;
      if (load_ready !== (idx < D) || busy !== (idx < D) || load_done !== (idx == D && lv)) begin
        bad++;
        $display("FAIL load_step[%0d] got rdy=%b busy=%b done=%b want rdy=%b done=%b",
                 idx, load_ready, busy, load_done, idx < D, idx == D && lv);
      end
    end
    load_valid = 1'b0;
    if (idx < D) begin
      bad++;
      $display("FAIL load_timeout got %0d words want %0d", idx, D);
    end
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    total++;
    if (load_ready !== 1'b1 || busy !== 1'b1 || load_done !== 1'b0) begin
      bad++;
      $display("FAIL start got rdy=%b busy=%b done=%b want 1 1 0", load_ready, busy, load_done);
    end
  endtask

  task automatic test_load_toggle();
    int dc;
    start_load();
    load_words(1, 8'h80, 1'b0, dc);
    // Done cycle: fetch issued now must see the freshly written word.
    fetch_valid = 1'b1;
    address     = 8'd7;
    tick();
    fetch_valid = 1'b0;
    exp_instr   = model_mem[7];
    if (load_done === 1'b1) dc++;
    total++;
    if (instr !== 8'h87 || instr !== exp_instr || instr_valid !== 1'b1) begin
      bad++;
      $display("FAIL load_toggle_fetch7 got %h v=%b want 87 v=1", instr, instr_valid);
    end
    total++;
    if (dc !== 1) begin
      bad++;
      $display("FAIL load_toggle_done_count got %0d want 1", dc);
    end
  endtask

  task automatic test_start_drops_fetch();
    load_start  = 1'b1;
    fetch_valid = 1'b1;
    address     = 8'd0;
    tick();
    load_start = 1'b0;
    total++;
    if (instr_valid !== 1'b0 || instr !== exp_instr || busy !== 1'b1) begin
      bad++;
      $display("FAIL start_drops_fetch got %h v=%b busy=%b want %h v=0 busy=1",
               instr, instr_valid, busy, exp_instr);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (instr_valid !== 1'b0 || instr !== exp_instr) begin
        bad++;
        $display("FAIL fetch_in_load[%0d] got %h v=%b want %h v=0", i, instr, instr_valid, exp_instr);
      end
    end
    fetch_valid = 1'b0;
  endtask

  // Entered while already in LOAD.
  task automatic test_restart();
    int dc;
    dc = 0;
    for (int i = 0; i < 10; i++) begin
      load_valid = 1'b1;
      load_data  = DW'($urandom);
      tick();
      model_mem[i] = load_data;
    end
    load_start = 1'b1;
    load_valid = 1'b1;
    load_data  = 8'hEE;
    tick();
    load_start = 1'b0;
    load_valid = 1'b0;
    total++;
    if (busy !== 1'b1 || load_done !== 1'b0) begin
      bad++;
      $display("FAIL restart got busy=%b done=%b want 1 0", busy, load_done);
    end
    load_words(0, 8'h10, 1'b0, dc);
    tick();
    if (load_done === 1'b1) dc++;
    total++;
    if (dc !== 1) begin
      bad++;
      $display("FAIL restart_done_count got %0d want 1", dc);
    end
    fetch_valid = 1'b1;
    address     = 8'd3;
    tick();
    fetch_valid = 1'b0;
    exp_instr   = model_mem[3];
    total++;
    if (instr !== 8'h13 || instr !== exp_instr || instr_valid !== 1'b1) begin
      bad++;
      $display("FAIL restart_fetch3 got %h v=%b want 13 v=1", instr, instr_valid);
    end
  endtask

  task automatic test_random();
    int dc;
    logic fv;
    start_load();
    load_words(2, 8'h00, 1'b1, dc);
    tick();
    exp_q.delete();
    for (int c = 0; c < 80; c++) begin
      fv          = ($urandom_range(0, 3) != 0);
      fetch_valid = fv;
      address     = AW'($urandom);
      if (fv) exp_q.push_back(model_mem[int'(address) % D]);
      tick();
      if (fv) exp_instr = exp_q.pop_front();
      total++;
      if (instr_valid !== fv || instr !== exp_instr) begin
        bad++;
        $display("FAIL random_fetch[%0d] addr=%h got %h v=%b want %h v=%b",
                 c, address, instr, instr_valid, exp_instr, fv);
      end
    end
    fetch_valid = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    start_load();
    for (int i = 0; i < 10; i++) begin
      load_valid = 1'b1;
      load_data  = 8'hFF;
      tick();
    end
    load_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_default();
    exp_instr = '0;
    total++;
    if (busy !== 1'b0 || load_ready !== 1'b0 || load_done !== 1'b0 || instr !== 8'h00) begin
      bad++;
      $display("FAIL reset_mid_load got busy=%b rdy=%b done=%b instr=%h want 0 0 0 00",
               busy, load_ready, load_done, instr);
    end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      fetch_valid = 1'b1;
      address     = (k == 0) ? 8'd0 : 8'd9;
      tick();
      exp_instr = model_mem[int'(address)];
      total++;
      if (instr !== exp_instr || instr_valid !== 1'b1 || load_done !== 1'b0) begin
        bad++;
        $display("FAIL post_reset_fetch addr=%0d got %h v=%b done=%b want %h v=1 done=0",
                 address, instr, instr_valid, load_done, exp_instr);
      end
    end
    total++;
    if (model_mem[0] !== 8'h49 || instr !== 8'h00) begin
      bad++;
      $display("FAIL default_restored got last=%h want 00", instr);
    end
    fetch_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fetch_default();
    test_wrap_and_hold();
    test_load_toggle();
    test_start_drops_fetch();
    test_restart();
    test_random();
    test_reset_mid_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
